// File: rtl/pcm_sample_fifo.sv
// pcm_sample_fifo
//
// Byte-wide PCM sample FIFO and frame assembler sitting directly upstream of
// the I2S DAC interface. The host pushes a little-endian byte stream (left
// channel first) in 8/16-bit, mono/stereo format. One frame is pulled from
// the FIFO, volume-scaled and staged ahead of each next_sample strobe, so the
// DAC-facing outputs only ever change on the cycle after a strobe.
//
// Parameters
//   DEPTH_LOG2         FIFO depth = 2**DEPTH_LOG2 bytes
//
// Ports
//   clk                system clock
//   rst_n              synchronous active-low reset
//   wr_en, wr_data     host byte push
//   fifo_reset         1-cycle clear of FIFO and frame staging (outputs hold)
//   cfg_stereo         1 = stereo frames, 0 = mono (right = left)
//   cfg_16bit          1 = 16-bit signed samples, 0 = 8-bit signed
//   cfg_volume         linear gain 0..15 (0 = mute)
//   next_sample        strobe from dacif; outputs are latched by dacif this cycle
//   left_data          24-bit two's complement left sample
//   right_data         24-bit two's complement right sample
//   fifo_full          count == depth
//   fifo_empty         count == 0
//   fifo_almost_empty  count < depth/4
//   overflow           1-cycle pulse: a write was dropped because FIFO was full
//   underrun           1-cycle pulse: no staged frame was available at a strobe
//
// State  | meaning
// -------+---------------------------------------------------------------
// CHECK  | decide: frame already staged -> IDLE, enough bytes -> FETCH
// FETCH  | issue NEED reads (down-counter), plus one drain cycle for the
//        | registered read data of the last byte
// SCALE  | build signed samples, apply volume, stage the frame
// IDLE   | frame staged, wait for next_sample

module pcm_sample_fifo #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        fifo_reset,
    input  logic        cfg_stereo,
    input  logic        cfg_16bit,
    input  logic [3:0]  cfg_volume,
    input  logic        next_sample,
    output logic [23:0] left_data,
    output logic [23:0] right_data,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        fifo_almost_empty,
    output logic        overflow,
    output logic        underrun
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] QUARTER_CNT = (DEPTH_LOG2 + 1)'(DEPTH / 4);

    typedef enum logic [1:0] {
        ST_CHECK = 2'd0,
        ST_FETCH = 2'd1,
        ST_SCALE = 2'd2,
        ST_IDLE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  push;
    logic                  pop;
    logic [7:0]            rd_q;
    logic                  rd_vld_q;

    logic [7:0]            slot [4];
    logic [1:0]            slot_idx;
    logic [2:0]            rd_left;
    logic [2:0]            need_now;
    logic                  fetch_start;

    logic                  stereo_q;
    logic                  b16_q;
    logic [3:0]            vol_q;

    logic [23:0]           staged_l;
    logic [23:0]           staged_r;
    logic                  staged_valid;

    logic signed [15:0]    s_left;
    logic signed [15:0]    s_right;
    logic signed [19:0]    p_left;
    logic signed [19:0]    p_right;

    assign fifo_full         = (count == DEPTH_CNT);
    assign fifo_empty        = (count == '0);
    assign fifo_almost_empty = (count < QUARTER_CNT);

    // Writes are dropped while full and on the fifo_reset cycle.
    assign push = wr_en && !fifo_full && !fifo_reset;
    assign pop  = (state == ST_FETCH) && (rd_left != 3'd0) && !fifo_reset;

    // Bytes per frame for the live configuration: 1, 2 or 4.
    always_comb begin
        need_now = 3'd1;
        case ({cfg_stereo, cfg_16bit})
            2'b00:   need_now = 3'd1;
            2'b01:   need_now = 3'd2;
            2'b10:   need_now = 3'd2;
            default: need_now = 3'd4;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        fetch_start = 1'b0;
        case (state)
            ST_CHECK: begin
                if (staged_valid) begin
                    state_nxt = ST_IDLE;
                end else if (count >= (DEPTH_LOG2 + 1)'(need_now)) begin
                    state_nxt   = ST_FETCH;
                    fetch_start = 1'b1;
                end
            end
            ST_FETCH: begin
                if (rd_left == 3'd0) begin
                    state_nxt = ST_SCALE;
                end
            end
            ST_SCALE: state_nxt = ST_IDLE;
            ST_IDLE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_CHECK;
        endcase
        // A strobe mid-FETCH/SCALE must not abort the fetch in flight;
        // otherwise the strobe returns the FSM to CHECK.
        if (next_sample && (state == ST_CHECK || state == ST_IDLE)) begin
            state_nxt   = ST_CHECK;
            fetch_start = 1'b0;
        end
        if (fifo_reset) begin
            state_nxt   = ST_CHECK;
            fetch_start = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_CHECK;
        end else begin
            state <= state_nxt;
        end
    end

    // Storage kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
        if (pop) begin
            rd_q <= mem[rd_ptr];
        end
    end

    // Sample construction: 8-bit samples sit in the upper byte of s16.
    // |s16 * vol| <= 32768 * 15, which always fits a 20-bit signed product.
    always_comb begin
        s_left  = b16_q ? {slot[1], slot[0]} : {slot[0], 8'h00};
        s_right = s_left;
        if (stereo_q) begin
            s_right = b16_q ? {slot[3], slot[2]} : {slot[1], 8'h00};
        end
        p_left  = 20'(s_left)  * 20'($signed({1'b0, vol_q}));
        p_right = 20'(s_right) * 20'($signed({1'b0, vol_q}));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_vld_q     <= 1'b0;
            rd_left      <= 3'd0;
            slot_idx     <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                slot[i] <= 8'h00;
            end
            stereo_q     <= 1'b0;
            b16_q        <= 1'b0;
            vol_q        <= 4'd0;
            staged_l     <= 24'd0;
            staged_r     <= 24'd0;
            staged_valid <= 1'b0;
            left_data    <= 24'd0;
            right_data   <= 24'd0;
            overflow     <= 1'b0;
            underrun     <= 1'b0;
        end else if (fifo_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_vld_q     <= 1'b0;
            rd_left      <= 3'd0;
            slot_idx     <= 2'd0;
            staged_valid <= 1'b0;
            overflow     <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            overflow <= wr_en && fifo_full;
            underrun <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            rd_vld_q <= pop;

            if (fetch_start) begin
                rd_left  <= need_now;
                slot_idx <= 2'd0;
                stereo_q <= cfg_stereo;
                b16_q    <= cfg_16bit;
                vol_q    <= cfg_volume;
            end else if (pop) begin
                rd_left <= rd_left - 1'b1;
            end

            if (rd_vld_q) begin
                slot[slot_idx] <= rd_q;
                slot_idx       <= slot_idx + 1'b1;
            end

            if (next_sample) begin
                if (staged_valid) begin
                    left_data    <= staged_l;
                    right_data   <= staged_r;
                    staged_valid <= 1'b0;
                end else begin
                    left_data  <= 24'd0;
                    right_data <= 24'd0;
                    underrun   <= 1'b1;
                end
            end

            // Placed after the strobe handling so a frame finishing in SCALE
            // stays staged even when the strobe in that cycle underran.
            if (state == ST_SCALE) begin
                staged_l     <= {p_left,  4'b0000};
                staged_r     <= {p_right, 4'b0000};
                staged_valid <= 1'b1;
            end
        end
    end

endmodule
